pc_sequencer: RTL and testbench

- Parametrised, registered program-counter unit for the RV32I core; successor to the combinational 3-way PC select.
- Owns the PC register, picks next PC from sequential / branch / jump / trap sources by fixed priority, and supports fetch stall.
- Holds a redirect that arrives during a stall in a one-entry pending buffer until the stall releases.
- Sits between the execute/trap logic and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered program counter with prioritised redirect (trap > jmp > br), fetch stall and
// a one-entry pending redirect buffer. Optional PC_ALIGN_CHECK_EN adds misalign reporting.
module pc_sequencer #(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] INC      = PC_W'(4)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            trap_en,
  input  logic [PC_W-1:0] trap_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            pc_valid,
  output logic            redirect,
  output logic            pend_valid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_BR   = 2'd1,
    PRI_JMP  = 2'd2,
    PRI_TRAP = 2'd3
  } pri_e;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            redirect_q, redirect_d;
  logic            pend_valid_q, pend_valid_d;
  pri_e            pend_pri_q, pend_pri_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  pri_e            new_pri;
  logic [PC_W-1:0] new_tgt;
  logic            new_wins;
  logic            load;
  logic [PC_W-1:0] load_tgt;

  always_comb begin
    new_pri = PRI_NONE;
    new_tgt = '0;
    if (trap_en) begin
      new_pri = PRI_TRAP;
      new_tgt = trap_target;
    end else if (jmp_en) begin
      new_pri = PRI_JMP;
      new_tgt = jmp_target;
    end else if (br_taken) begin
      new_pri = PRI_BR;
      new_tgt = br_target;
    end
  end

  // A new request beats an equal-priority pending one, both when capturing and when loading.
  assign new_wins = (new_pri != PRI_NONE) && (!pend_valid_q || (new_pri >= pend_pri_q));

  always_comb begin
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    redirect_d   = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_pri_d   = pend_pri_q;
    pend_tgt_d   = pend_tgt_q;
    load         = 1'b0;
    load_tgt     = '0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    if (!pc_valid_q || stall) begin
      // The first edge out of reset only validates pc; requests then behave as if stalled.
      pc_valid_d = 1'b1;
      if (new_wins) begin
        pend_valid_d = 1'b1;
        pend_pri_d   = new_pri;
        pend_tgt_d   = new_tgt;
      end
    end else begin
      if (new_wins) begin
        load     = 1'b1;
        load_tgt = new_tgt;
      end else if (pend_valid_q) begin
        load     = 1'b1;
        load_tgt = pend_tgt_q;
      end
      if (load) begin
        redirect_d   = 1'b1;
        pend_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        pc_d       = {load_tgt[PC_W-1:2], 2'b00};
        misalign_d = |load_tgt[1:0];
`else
        pc_d       = load_tgt;
`endif
      end else begin
        pc_d = pc_q + INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      redirect_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pri_q   <= PRI_NONE;
      pend_tgt_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      redirect_q   <= redirect_d;
      pend_valid_q <= pend_valid_d;
      pend_pri_q   <= pend_pri_d;
      pend_tgt_q   <= pend_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign pc_plus    = pc_q + INC;
  assign pc_valid   = pc_valid_q;
  assign redirect   = redirect_q;
  assign pend_valid = pend_valid_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes expected post-edge state from a
// behavioural model, a monitor pops and compares one entry per clock.
module tb_pc_sequencer;

  localparam int PC_W = 12;
  localparam int MODV = 4096;

  logic            clk = 1'b0;
  logic            rst, stall, br_taken, jmp_en, trap_en;
  logic [PC_W-1:0] br_target, jmp_target, trap_target;
  logic [PC_W-1:0] pc, pc_plus;
  logic            pc_valid, redirect, pend_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic            misalign;
`endif

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(12'h000), .INC(12'h004)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_en(jmp_en), .jmp_target(jmp_target),
    .trap_en(trap_en), .trap_target(trap_target),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
    .redirect(redirect), .pend_valid(pend_valid)
`ifdef PC_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int pc_plus;
    int pc_valid;
    int redirect;
    int pend_valid;
    int misalign;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int m_pc = 0, m_valid = 0, m_pv = 0, m_ppri = 0, m_ptgt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", 32'(pc), e.pc);
        chk("pc_plus", 32'(pc_plus), e.pc_plus);
        chk("pc_valid", 32'(pc_valid), e.pc_valid);
        chk("redirect", 32'(redirect), e.redirect);
        chk("pend_valid", 32'(pend_valid), e.pend_valid);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign", 32'(misalign), e.misalign);
`endif
      end
    end
  end

  task automatic model_step(input int r, input int s, input int b, input int bt,
                            input int j, input int jt, input int t, input int tt);
    int   req_pri, req_tgt, tgt, take;
    exp_t e;
    e.redirect = 0;
    e.misalign = 0;
    if (r != 0) begin
      m_pc = 0; m_valid = 0; m_pv = 0; m_ppri = 0; m_ptgt = 0;
    end else begin
      req_pri = t ? 3 : j ? 2 : b ? 1 : 0;
      req_tgt = t ? tt : j ? jt : b ? bt : 0;
      if (m_valid == 0 || s != 0) begin
        m_valid = 1;
        if (req_pri > 0 && (m_pv == 0 || req_pri >= m_ppri)) begin
          m_pv = 1; m_ppri = req_pri; m_ptgt = req_tgt;
        end
      end else begin
        take = 1;
        if (req_pri > 0 && (m_pv == 0 || req_pri >= m_ppri)) tgt = req_tgt;
        else if (m_pv != 0) tgt = m_ptgt;
        else take = 0;
        if (take != 0) begin
`ifdef PC_ALIGN_CHECK_EN
          e.misalign = (tgt % 4 != 0) ? 1 : 0;
          tgt = tgt - (tgt % 4);
`endif
          m_pc = tgt;
          m_pv = 0;
          e.redirect = 1;
        end else begin
          m_pc = (m_pc + 4) % MODV;
        end
      end
    end
    e.pc = m_pc;
    e.pc_plus = (m_pc + 4) % MODV;
    e.pc_valid = m_valid;
    e.pend_valid = m_pv;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int r, input int s, input int b, input int bt,
                       input int j, input int jt, input int t, input int tt);
    @(negedge clk);
    rst = r[0]; stall = s[0];
    br_taken = b[0];   br_target   = bt[PC_W-1:0];
    jmp_en = j[0];     jmp_target  = jt[PC_W-1:0];
    trap_en = t[0];    trap_target = tt[PC_W-1:0];
    model_step(r, s, b, bt, j, jt, t, tt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    int budget;
    rst = 1'b1; stall = 1'b0;
    br_taken = 1'b0; jmp_en = 1'b0; trap_en = 1'b0;
    br_target = '0; jmp_target = '0; trap_target = '0;

    // Reset, then release: 0, 4, 8, C, 10
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // Simultaneous br + jmp at pc=0x010: jmp wins, then sequential 0x204
    drive(0, 0, 1, 'h100, 1, 'h200, 0, 0);
    idle(1);
    // Move to 0x020, stall with br then trap replacement, release
    drive(0, 0, 0, 0, 1, 'h020, 0, 0);
    drive(0, 1, 1, 'h080, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 'h3F0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Pending jmp beats a lower-priority br at release
    drive(0, 1, 0, 0, 1, 'h400, 0, 0);
    drive(0, 0, 1, 'h500, 0, 0, 0, 0);
    // Lower-priority request while a trap is pending is dropped; equal priority replaces
    drive(0, 1, 0, 0, 0, 0, 1, 'h600);
    drive(0, 1, 1, 'h700, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 'h640);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Tie at release goes to the new request
    drive(0, 1, 0, 0, 1, 'h800, 0, 0);
    drive(0, 0, 0, 0, 1, 'h840, 0, 0);
    // Wrap-around from 0xFFC
    drive(0, 0, 0, 0, 1, 'hFFC, 0, 0);
    idle(2);
    // Misaligned target (verbatim without the align check)
    drive(0, 0, 0, 0, 1, 'h10A, 0, 0);
    idle(1);
    // Reset while stalled with a pending entry, then requests on the validating edge
    drive(0, 1, 1, 'h0F0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 'h0A0, 0, 0, 0, 0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0) ? 1 : 0,
            ($urandom_range(0, 9) < 3) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, MODV - 1)),
            ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, MODV - 1)),
            ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, MODV - 1)));
    end
    idle(2);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
